// File: rtl/main_ctr_if.sv
// main_ctr_if: control-unit bundle between main_ctr (master) and the datapath (slave).
interface main_ctr_if #(parameter int OPW = 6);
  logic [OPW-1:0] opcode;
  logic           mem_ready;
  logic [2:0]     ALUop;
  logic           pc_write;
  logic           pc_write_cond;
  logic           ir_write;
  logic           mem_read;
  logic           mem_write;
  logic           i_or_d;
  logic           mem_to_reg;
  logic           reg_dst;
  logic           reg_write;
  logic           alu_src_a;
  logic [1:0]     alu_src_b;
  logic [1:0]     pc_source;
  logic [3:0]     state;
  logic           illegal;
  modport master (
    input  opcode, mem_ready,
    output ALUop, pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source, state, illegal
  );
  modport slave (
    output opcode, mem_ready,
    input  ALUop, pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source, state, illegal
  );
endinterface

// File: rtl/main_ctr.sv
// main_ctr: multi-cycle A2K main control FSM; define MAIN_CTR_TRAP_EN to trap on illegal opcodes.
module main_ctr #(parameter int OPW = 6) (
  input  logic       clk,
  input  logic       rst_n,
  main_ctr_if.master bus
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, BRANCH, JUMP, I_EXEC, I_WB, TRAP
  } state_t;
  localparam logic [OPW-1:0] OP_R    = OPW'(6'h00);
  localparam logic [OPW-1:0] OP_LW   = OPW'(6'h23);
  localparam logic [OPW-1:0] OP_SW   = OPW'(6'h2B);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'h04);
  localparam logic [OPW-1:0] OP_J    = OPW'(6'h02);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(6'h08);
  localparam logic [OPW-1:0] OP_ANDI = OPW'(6'h0C);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(6'h0D);
`ifdef MAIN_CTR_TRAP_EN
  localparam state_t ILL_NXT = TRAP;
`else
  localparam state_t ILL_NXT = FETCH;
`endif
  state_t         st, nxt;
  logic [OPW-1:0] op_q;
  logic           is_i;
  logic           legal;
  assign is_i  = bus.opcode == OP_ADDI || bus.opcode == OP_ANDI || bus.opcode == OP_ORI;
  assign legal = is_i || bus.opcode == OP_R || bus.opcode == OP_LW || bus.opcode == OP_SW ||
                 bus.opcode == OP_BEQ || bus.opcode == OP_J;
  assign bus.state = st;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st   <= FETCH;
      op_q <= '0;
    end else begin
      st <= nxt;
      if (st == DECODE) op_q <= bus.opcode;
    end
  // Outputs are forced to their idle values while reset is held, even though FETCH is the reset state.
  always_comb begin
    nxt               = st;
    bus.ALUop         = 3'b001;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.pc_source     = 2'b00;
    bus.illegal       = 1'b0;
    case (st)
      FETCH: begin
        bus.mem_read  = rst_n;
        bus.alu_src_b = rst_n ? 2'b01 : 2'b00;
        bus.ir_write  = rst_n && bus.mem_ready;
        bus.pc_write  = rst_n && bus.mem_ready;
        nxt           = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        bus.alu_src_b = 2'b11;
        bus.illegal   = !legal;
        nxt = (bus.opcode == OP_LW || bus.opcode == OP_SW) ? MEM_ADDR :
              bus.opcode == OP_R   ? R_EXEC :
              bus.opcode == OP_BEQ ? BRANCH :
              bus.opcode == OP_J   ? JUMP   :
              is_i                 ? I_EXEC : ILL_NXT;
      end
      MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        nxt           = op_q == OP_LW ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
        nxt          = bus.mem_ready ? MEM_WB : MEM_RD;
      end
      MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        nxt            = FETCH;
      end
      MEM_WR: begin
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
        nxt           = bus.mem_ready ? FETCH : MEM_WR;
      end
      R_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.ALUop     = 3'b000;
        nxt           = R_WB;
      end
      R_WB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
        nxt           = FETCH;
      end
      BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.ALUop         = 3'b011;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = 2'b01;
        nxt               = FETCH;
      end
      JUMP: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = 2'b10;
        nxt           = FETCH;
      end
      I_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.ALUop     = op_q == OP_ANDI ? 3'b101 : op_q == OP_ORI ? 3'b111 : 3'b001;
        nxt           = I_WB;
      end
      I_WB: begin
        bus.reg_write = 1'b1;
        nxt           = FETCH;
      end
      TRAP: bus.illegal = 1'b1;
      default: nxt = FETCH;
    endcase
  end
endmodule

// File: tb/tb_main_ctr.sv
// tb_main_ctr: randomized scoreboard bench for main_ctr; honours MAIN_CTR_TRAP_EN like the design.
module tb_main_ctr;
  typedef struct packed {
    logic [3:0] st;
    logic [2:0] aluop;
    logic       pcw, pcwc, irw, mrd, mwr, iod, m2r, rdst, rw, asa;
    logic [1:0] asb, pcs;
    logic       ill;
  } ov_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  main_ctr_if bus ();
  main_ctr dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  ov_t        expq[$];
  int         checks = 0;
  int         failures = 0;
  logic [5:0] opq_m = 6'h00;
  logic [5:0] legal_ops[8] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h0C, 6'h0D};
  function automatic bit legal(logic [5:0] o);
    return o inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h0C, 6'h0D};
  endfunction
  function automatic logic [5:0] rnd();
    return 6'($urandom);
  endfunction
  function automatic bit rb();
    return 1'($urandom);
  endfunction
  // Expected outputs for one cycle, straight from the per-state output table.
  function automatic ov_t model(int st, bit mr, bit rst, logic [5:0] opq, logic [5:0] opc);
    ov_t o = '0;
    o.aluop = 3'b001;
    if (rst) return o;
    o.st = 4'(st);
    case (st)
      0: begin o.mrd = 1; o.asb = 2'b01; o.irw = mr; o.pcw = mr; end
      1: begin o.asb = 2'b11; o.ill = !legal(opc); end
      2: begin o.asa = 1; o.asb = 2'b10; end
      3: begin o.mrd = 1; o.iod = 1; end
      4: begin o.rw = 1; o.m2r = 1; end
      5: begin o.mwr = 1; o.iod = 1; end
      6: begin o.asa = 1; o.aluop = 3'b000; end
      7: begin o.rw = 1; o.rdst = 1; end
      8: begin o.asa = 1; o.aluop = 3'b011; o.pcwc = 1; o.pcs = 2'b01; end
      9: begin o.pcw = 1; o.pcs = 2'b10; end
      10: begin o.asa = 1; o.asb = 2'b10; o.aluop = opq == 6'h0C ? 3'b101 : opq == 6'h0D ? 3'b111 : 3'b001; end
      11: o.rw = 1;
      12: o.ill = 1;
      default: ;
    endcase
    return o;
  endfunction
  task automatic cyc(int st, bit mr, bit rst, logic [5:0] opc);
    rst_n = !rst;
    bus.mem_ready = mr;
    bus.opcode = opc;
    expq.push_back(model(st, mr, rst, opq_m, opc));
    if (rst) opq_m = 6'h00;
    else if (st == 1) opq_m = opc;
    @(posedge clk);
    #1;
  endtask
  task automatic mem_wait(int st, int w);
    repeat (w) cyc(st, 1'b0, 1'b0, rnd());
    cyc(st, 1'b1, 1'b0, rnd());
  endtask
  task automatic instr(logic [5:0] op, int fw, int mw);
    mem_wait(0, fw);
    cyc(1, rb(), 1'b0, op);
    case (op)
      6'h23: begin cyc(2, rb(), 1'b0, rnd()); mem_wait(3, mw); cyc(4, rb(), 1'b0, rnd()); end
      6'h2B: begin cyc(2, rb(), 1'b0, rnd()); mem_wait(5, mw); end
      6'h00: begin cyc(6, rb(), 1'b0, rnd()); cyc(7, rb(), 1'b0, rnd()); end
      6'h04: cyc(8, rb(), 1'b0, rnd());
      6'h02: cyc(9, rb(), 1'b0, rnd());
      6'h08, 6'h0C, 6'h0D: begin cyc(10, rb(), 1'b0, rnd()); cyc(11, rb(), 1'b0, rnd()); end
`ifdef MAIN_CTR_TRAP_EN
      default: repeat (12) cyc(12, rb(), 1'b0, rnd());
`else
      default: ;
`endif
    endcase
  endtask
  always @(negedge clk) begin
    ov_t e, a;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      a = {bus.state, bus.ALUop, bus.pc_write, bus.pc_write_cond, bus.ir_write, bus.mem_read,
           bus.mem_write, bus.i_or_d, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
           bus.alu_src_b, bus.pc_source, bus.illegal};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL cycle_outputs exp_state=%0d got=%h exp=%h", e.st, a, e);
      end
    end
  end
  initial begin
    logic [5:0] op;
    bus.mem_ready = 1'b0;
    bus.opcode = 6'h00;
    @(posedge clk);
    #1;
    repeat (3) cyc(0, rb(), 1'b1, rnd());
    instr(6'h00, 0, 0);
    instr(6'h23, 0, 2);
    instr(6'h04, 1, 0);
    instr(6'h0D, 0, 0);
    instr(6'h0C, 2, 0);
    instr(6'h08, 0, 0);
    instr(6'h2B, 0, 1);
    instr(6'h02, 0, 0);
`ifndef MAIN_CTR_TRAP_EN
    instr(6'h3F, 0, 0);
`endif
    repeat (60) begin
      op = $urandom_range(0, 3) == 0 ? rnd() : legal_ops[$urandom_range(0, 7)];
`ifdef MAIN_CTR_TRAP_EN
      if (!legal(op)) op = legal_ops[$urandom_range(0, 7)];
`endif
      instr(op, $urandom_range(0, 2), $urandom_range(0, 2));
    end
    mem_wait(0, 0);
    cyc(1, rb(), 1'b0, 6'h2B);
    cyc(2, rb(), 1'b0, rnd());
    cyc(5, 1'b0, 1'b0, rnd());
    cyc(0, rb(), 1'b1, rnd());
    cyc(0, rb(), 1'b1, rnd());
    instr(6'h00, 0, 0);
`ifdef MAIN_CTR_TRAP_EN
    instr(6'h3F, 0, 0);
    cyc(0, rb(), 1'b1, rnd());
    instr(6'h04, 0, 0);
`endif
    @(negedge clk);
    #1;
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d required=0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/main_ctr.md
# main_ctr

Multi-cycle main control unit for the A2K CPU datapath. It sits directly upstream of the ALU control block: it latches the instruction opcode, sequences fetch/decode/execute/memory/write-back states, and drives every datapath strobe plus the 3-bit `ALUop` that the ALU control block combines with `func` to select the ALU operation. Memory accesses stall on a ready handshake.

## Interface
- `OPW`, 6: opcode width.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `opcode`  in  OPW  instruction-register opcode field; valid from DECODE onward.
- `mem_ready`  in  1  memory completes the current read/write this cycle.
- `ALUop`  out  3  to ALU control: 000 R-type (use func), 001 add, 011 sub, 101 and, 111 or.
- `pc_write`, `pc_write_cond`, `ir_write`, `mem_read`, `mem_write`, `i_or_d`, `mem_to_reg`, `reg_dst`, `reg_write`, `alu_src_a`  out  1 each  datapath strobes and selects.
- `alu_src_b`  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2.
- `pc_source`  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- `state`  out  4  current state encoding (debug).
- `illegal`  out  1  undefined opcode flag.

## Operation
- Opcodes: R 0x00, LW 0x23, SW 0x2B, BEQ 0x04, J 0x02, ADDI 0x08, ANDI 0x0C, ORI 0x0D; anything else illegal.
- States/encoding: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, I_EXEC 10, I_WB 11, TRAP 12.
- FETCH: `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `ALUop`=001, `pc_source`=00; `ir_write` and `pc_write` asserted only when `mem_ready`=1; advance to DECODE on `mem_ready`, else hold.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, `ALUop`=001; latch `opcode` into internal `op_q`; branch on opcode: LW/SW->MEM_ADDR, R->R_EXEC, BEQ->BRANCH, J->JUMP, ADDI/ANDI/ORI->I_EXEC, other->illegal path.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `ALUop`=001; ->MEM_RD if `op_q`=LW, else MEM_WR.
- MEM_RD: `mem_read`=1, `i_or_d`=1; hold until `mem_ready`, then MEM_WB. MEM_WB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0; ->FETCH.
- MEM_WR: `mem_write`=1, `i_or_d`=1; hold until `mem_ready`, then FETCH.
- R_EXEC: `alu_src_a`=1, `alu_src_b`=00, `ALUop`=000; ->R_WB. R_WB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0; ->FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `ALUop`=011, `pc_write_cond`=1, `pc_source`=01; ->FETCH.
- JUMP: `pc_write`=1, `pc_source`=10; ->FETCH.
- I_EXEC: `alu_src_a`=1, `alu_src_b`=10, `ALUop` = 001/101/111 for ADDI/ANDI/ORI (from `op_q`); ->I_WB. I_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0; ->FETCH.
- Signals not listed for a state are 0; `ALUop` defaults to 001.
- `opcode` changes outside DECODE have no effect (only `op_q` is used after DECODE).

## Timing
- State register updates on rising `clk`; outputs are combinational from state (plus `mem_ready` gating and `op_q`).
- Cycles per instruction with `mem_ready` tied high: LW 5, SW 4, R 4, ADDI/ANDI/ORI 4, BEQ 3, J 3. Each low-`mem_ready` cycle in FETCH/MEM_RD/MEM_WR adds one cycle.
- Reset: `rst_n` low forces state=FETCH, `op_q`=0, `illegal`=0 immediately; while `rst_n` low all strobes (`pc_write`, `pc_write_cond`, `ir_write`, `mem_read`, `mem_write`, `reg_write`) are 0, selects 0, `ALUop`=001. First FETCH access on first rising edge after release. Reset mid-instruction aborts with no further writes.
- `mem_ready` high in non-memory states is ignored.

## Configuration
- `MAIN_CTR_TRAP_EN` defined: illegal opcode in DECODE -> TRAP; TRAP holds forever with all strobes 0, `illegal`=1 (sticky) until reset.
- Not defined: illegal opcode -> FETCH (executes as 2-cycle NOP), `illegal` pulses 1 during that DECODE cycle only; TRAP state unreachable.

## Test plan
- Reset with `rst_n`=0, toggle `clk` -> state=0, all strobes 0; release -> `mem_read`=1, `ALUop`=001 next cycle.
- R-type (opcode 0x00), `mem_ready`=1 -> states 0,1,6,7,0; `ALUop`=000 in state 6; `reg_write`=1,`reg_dst`=1 in state 7.
- LW (0x23) with `mem_ready` low 2 cycles in MEM_RD -> states 0,1,2,3,3,3,4,0; `i_or_d`=1 throughout state 3.
- BEQ (0x04) -> `ALUop`=011, `pc_write_cond`=1 in state 8; ORI (0x0D) -> `ALUop`=111 in state 10; ANDI -> 101.
- Opcode 0x3F: with `MAIN_CTR_TRAP_EN` -> state 12, `illegal` stays 1 for 10+ cycles; without -> back to state 0, `illegal` high exactly one cycle.
- Assert `rst_n` low during MEM_WR -> `mem_write` drops same cycle, state=0.
